// File: rtl/apb_slave_regfile_if.sv
// rtl/apb_slave_regfile_if.sv - APB slot bus between the initiator and the register-file responder
interface apb_slave_regfile_if;
  logic        sel;
  logic        en;
  logic        wr;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        slverr;

  modport master (
    output sel, en, wr, addr, wdata,
    input  rdata, ready, slverr
  );

  modport slave (
    input  sel, en, wr, addr, wdata,
    output rdata, ready, slverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB responder with wait states, a control register file and a read-only status word
module apb_slave_regfile #(
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  apb_slave_regfile_if.slave        bus,
  input  logic [31:0]               status_in,
  output logic [31:0]               ctrl_out,
  output logic                      wr_pulse,
  output logic [9:0]                wr_idx
);

  localparam int IW = (NUM_REGS > 2) ? $clog2(NUM_REGS - 1) : 1;
  localparam logic [10:0] NUM_W    = 11'(NUM_REGS);
  localparam logic [10:0] STATUS_W = 11'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        req_wr;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] regs [NUM_REGS-1];

  logic        take, dec, done;
  logic [9:0]  req_idx;
  logic [10:0] idx_ext;
  logic [IW-1:0] ridx;
  logic        is_status, err;
  logic [31:0] rd_val;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    dec       = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sel && !bus.en) begin
          take      = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // en is deliberately ignored here; only losing sel abandons the slot
        if (!bus.sel) begin
          state_nxt = IDLE;
        end else if (cnt != 4'd0) begin
          dec = 1'b1;
        end else begin
          done      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.sel && !bus.en) begin
          take      = 1'b1;
          state_nxt = WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decode of the request latched at setup; upper index bits still count toward range
  always_comb begin
    req_idx   = req_addr[11:2];
    idx_ext   = {1'b0, req_idx};
    ridx      = req_idx[IW-1:0];
    is_status = (idx_ext == STATUS_W);
    err       = (req_addr[1:0] != 2'b00) || (idx_ext >= NUM_W) || (req_wr && is_status);
    rd_val    = is_status ? status_in : regs[ridx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 4'd0;
      req_wr     <= 1'b0;
      req_addr   <= 12'd0;
      req_wdata  <= 32'd0;
      bus.rdata  <= 32'd0;
      bus.ready  <= 1'b0;
      bus.slverr <= 1'b0;
      wr_pulse   <= 1'b0;
      wr_idx     <= 10'd0;
      for (int i = 0; i < NUM_REGS - 1; i++) regs[i] <= 32'd0;
    end else begin
      bus.ready  <= done;
      bus.slverr <= done && err;
      bus.rdata  <= (done && !err && !req_wr) ? rd_val : 32'd0;
      wr_pulse   <= done && req_wr && !err;
      if (take) begin
        req_wr    <= bus.wr;
        req_addr  <= bus.addr;
        req_wdata <= bus.wdata;
        cnt       <= 4'(WAIT_CYCLES);
      end else if (dec) begin
        cnt <= cnt - 4'd1;
      end
      if (done && req_wr && !err) begin
        regs[ridx] <= req_wdata;
        wr_idx     <= req_idx;
      end
    end
  end

  assign ctrl_out = regs[0];

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - self-checking bench for apb_slave_regfile against a register-array model
module tb_apb_slave_regfile;
  localparam int NR = 16;
  localparam int W1 = 1;
  localparam int W3 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_slave_regfile_if if1 ();
  apb_slave_regfile_if if3 ();

  logic        b_sel, b_en, b_wr;
  logic [11:0] b_addr;
  logic [31:0] b_wdata;
  logic        sel3;
  logic [31:0] status_in;
  logic [31:0] ctrl1, ctrl3;
  logic        wp1, wp3;
  logic [9:0]  wi1, wi3;

  assign if1.sel   = b_sel && !sel3;
  assign if3.sel   = b_sel && sel3;
  assign if1.en    = b_en;
  assign if3.en    = b_en;
  assign if1.wr    = b_wr;
  assign if3.wr    = b_wr;
  assign if1.addr  = b_addr;
  assign if3.addr  = b_addr;
  assign if1.wdata = b_wdata;
  assign if3.wdata = b_wdata;

  apb_slave_regfile #(.NUM_REGS(NR), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .status_in(status_in),
    .ctrl_out(ctrl1), .wr_pulse(wp1), .wr_idx(wi1)
  );

  apb_slave_regfile #(.NUM_REGS(NR), .WAIT_CYCLES(W3)) dut3 (
    .clk(clk), .rst(rst), .bus(if3), .status_in(status_in),
    .ctrl_out(ctrl3), .wr_pulse(wp3), .wr_idx(wi3)
  );

  logic        s_ready, s_slverr, s_wp;
  logic [31:0] s_rdata, s_ctrl;
  logic [9:0]  s_wi;
  assign s_ready  = sel3 ? if3.ready  : if1.ready;
  assign s_slverr = sel3 ? if3.slverr : if1.slverr;
  assign s_rdata  = sel3 ? if3.rdata  : if1.rdata;
  assign s_ctrl   = sel3 ? ctrl3 : ctrl1;
  assign s_wp     = sel3 ? wp3 : wp1;
  assign s_wi     = sel3 ? wi3 : wi1;

  int errors = 0;
  int checks = 0;
  logic [31:0] m1 [NR];
  logic [31:0] m3 [NR];
  logic        cur_w;
  logic [11:0] cur_a;
  logic [31:0] cur_d;
  logic [31:0] rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mget(input int i);
    return sel3 ? m3[i] : m1[i];
  endfunction

  task automatic mput(input int i, input logic [31:0] v);
    if (sel3) m3[i] = v;
    else      m1[i] = v;
  endtask

  task automatic setup(input logic w, input logic [11:0] a, input logic [31:0] d);
    b_sel = 1'b1; b_en = 1'b0; b_wr = w; b_addr = a; b_wdata = d;
    cur_w = w; cur_a = a; cur_d = d;
  endtask

  // Waits for ready after a setup and scores the response against the model
  task automatic complete(input string tag, input bit perturb, output logic [31:0] rdo);
    int  n, wc, idx;
    bit  err;
    logic [31:0] exp_rd;
    wc = sel3 ? W3 : W1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) b_en = 1'b1;
      if (!s_ready) begin
        chk({tag, "_early_wr_pulse"}, {31'd0, s_wp}, 32'd0);
        if (perturb) begin
          b_addr = 12'($urandom); b_wdata = $urandom; b_wr = 1'($urandom); b_en = 1'($urandom);
        end
      end
    end while (!s_ready && n < 40);
    chk({tag, "_latency"}, 32'(n), 32'(wc + 2));
    rdo = s_rdata;
    idx = int'(cur_a[11:2]);
    err = (cur_a[1:0] != 2'b00) || (idx >= NR) || (cur_w && idx == NR - 1);
    chk({tag, "_slverr"}, {31'd0, s_slverr}, {31'd0, err});
    if (err || !cur_w) begin
      exp_rd = err ? 32'd0 : (idx == NR - 1) ? status_in : mget(idx);
      chk({tag, "_rdata"}, s_rdata, exp_rd);
    end
    if (!err && cur_w) mput(idx, cur_d);
    chk({tag, "_wr_pulse"}, {31'd0, s_wp}, {31'd0, (!err && cur_w)});
    if (!err && cur_w) chk({tag, "_wr_idx"}, 32'(s_wi), 32'(idx));
    chk({tag, "_ctrl_out"}, s_ctrl, mget(0));
  endtask

  task automatic xfer(input string tag, input logic w, input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    setup(w, a, d);
    complete(tag, 1'b0, rd);
    b_sel = 1'b0; b_en = 1'b0;
  endtask

  task automatic gen_setup();
    int r;
    logic [11:0] a;
    r = $urandom_range(0, 9);
    if (r == 0)      a = 12'($urandom);
    else if (r == 1) a = 12'($urandom_range(0, NR - 1) * 4 + $urandom_range(1, 3));
    else             a = 12'($urandom_range(0, NR) * 4);
    status_in = $urandom;
    setup(1'($urandom), a, $urandom);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready1"}, {31'd0, if1.ready}, 32'd0);
    chk({tag, "_rdata1"}, if1.rdata, 32'd0);
    chk({tag, "_slverr1"}, {31'd0, if1.slverr}, 32'd0);
    chk({tag, "_ctrl1"}, ctrl1, 32'd0);
    chk({tag, "_wp1"}, {31'd0, wp1}, 32'd0);
    chk({tag, "_wi1"}, 32'(wi1), 32'd0);
    chk({tag, "_ready3"}, {31'd0, if3.ready}, 32'd0);
    chk({tag, "_rdata3"}, if3.rdata, 32'd0);
    chk({tag, "_slverr3"}, {31'd0, if3.slverr}, 32'd0);
    chk({tag, "_ctrl3"}, ctrl3, 32'd0);
    chk({tag, "_wp3"}, {31'd0, wp3}, 32'd0);
    chk({tag, "_wi3"}, 32'(wi3), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin m1[i] = 32'd0; m3[i] = 32'd0; end
    sel3 = 1'b0; b_sel = 1'b0; b_en = 1'b0; b_wr = 1'b0; b_addr = 12'd0; b_wdata = 32'd0;
    status_in = 32'd0; cur_w = 1'b0; cur_a = 12'd0; cur_d = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;

    xfer("rd0", 1'b0, 12'h000, 32'd0);
    chk("rd0_value", rd, 32'h0000_0000);

    xfer("wr0", 1'b1, 12'h000, 32'hDEAD_BEEF);
    chk("wr0_ctrl_const", ctrl1, 32'hDEAD_BEEF);
    xfer("rb0", 1'b0, 12'h000, 32'd0);
    chk("rb0_value", rd, 32'hDEAD_BEEF);

    xfer("err_misaligned", 1'b1, 12'h002, 32'h1);
    xfer("err_range", 1'b1, 12'h040, 32'h1);
    xfer("err_status_wr", 1'b1, 12'h03C, 32'h1);
    xfer("err_range_rd", 1'b0, 12'h040, 32'd0);
    xfer("rb0_after_err", 1'b0, 12'h000, 32'd0);
    chk("rb0_after_err_value", rd, 32'hDEAD_BEEF);

    status_in = 32'hA5A5_0001;
    xfer("status_rd", 1'b0, 12'h03C, 32'd0);
    chk("status_value", rd, 32'hA5A5_0001);

    @(negedge clk);
    setup(1'b1, 12'h004, 32'h11);
    complete("b2b_wr", 1'b0, rd);
    setup(1'b0, 12'h004, 32'd0);
    complete("b2b_rd", 1'b0, rd);
    b_sel = 1'b0; b_en = 1'b0;
    chk("b2b_value", rd, 32'h0000_0011);
    @(negedge clk);
    chk("ready_drops", {31'd0, if1.ready}, 32'd0);

    @(negedge clk);
    gen_setup();
    for (int i = 0; i < 60; i++) begin
      complete("rnd", 1'b1, rd);
      if (i < 59 && $urandom_range(0, 3) == 0) begin
        gen_setup();
      end else begin
        b_sel = 1'b0; b_en = 1'b0;
        if (i < 59) begin
          @(negedge clk);
          gen_setup();
        end
      end
    end

    sel3 = 1'b1;
    status_in = 32'd0;
    xfer("w3_wr0", 1'b1, 12'h000, 32'h1234_5678);
    xfer("w3_wr5", 1'b1, 12'h014, 32'h77);

    @(negedge clk);
    setup(1'b1, 12'h008, 32'h55);
    @(negedge clk);
    b_en = 1'b1;
    @(negedge clk);
    b_sel = 1'b0; b_en = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("abort_ready", {31'd0, if3.ready}, 32'd0);
      chk("abort_wr_pulse", {31'd0, wp3}, 32'd0);
    end
    xfer("abort_rb", 1'b0, 12'h008, 32'd0);
    chk("abort_rb_value", rd, 32'h0000_0000);

    @(negedge clk);
    setup(1'b1, 12'h00C, 32'h99);
    @(negedge clk);
    b_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero_outputs("mid_reset");
    rst = 1'b0; b_sel = 1'b0; b_en = 1'b0;
    for (int i = 0; i < NR; i++) begin m1[i] = 32'd0; m3[i] = 32'd0; end
    xfer("post_rst_rd0", 1'b0, 12'h000, 32'd0);
    chk("post_rst_rd0_value", rd, 32'h0000_0000);
    xfer("post_rst_rd3", 1'b0, 12'h00C, 32'd0);
    chk("post_rst_rd3_value", rd, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
